// File: rtl/corr_readout_master_pkg.sv
// Shared constants for the correlator readout master: register map, STATUS bits,
// frame field width, sequencer state encoding and the read-sequence address table.
package corr_readout_master_pkg;

    localparam logic [7:0] ADR_STATUS = 8'h30;
    localparam logic [7:0] ADR_PI     = 8'h18;
    localparam logic [7:0] ADR_PQ     = 8'h1C;
    localparam logic [7:0] ADR_LI     = 8'h20;
    localparam logic [7:0] ADR_LQ     = 8'h24;
    localparam logic [7:0] ADR_EI     = 8'h28;
    localparam logic [7:0] ADR_EQ     = 8'h2C;
    localparam logic [7:0] ADR_SAT    = 8'h38;

    localparam int STATUS_RDY_BIT = 0;
    localparam int STATUS_ACQ_BIT = 1;
    localparam int FRM_W          = 20;
    localparam int SAT_ID_W       = 5;
    localparam int SAT_CHG_BIT    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_CLR,
        ST_OUT
    } seq_state_t;

    // Index 0 is the STATUS poll; the SAT entry is only reached when that read is enabled.
    function automatic logic [7:0] seq_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    return ADR_STATUS;
            3'd1:    return ADR_PI;
            3'd2:    return ADR_PQ;
            3'd3:    return ADR_LI;
            3'd4:    return ADR_LQ;
            3'd5:    return ADR_EI;
            3'd6:    return ADR_EQ;
            default: return ADR_SAT;
        endcase
    endfunction

endpackage

// File: rtl/corr_readout_master_wb_single_xfer.sv
// One Wishbone classic transaction at a time: holds stb/cyc until ack or timeout and,
// for reads, waits RD_LAT cycles after ack before flagging the read data as valid.
module corr_readout_master_wb_single_xfer #(
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic        we,
    input  logic [7:0]  adr,
    input  logic [31:0] wdat,
    output logic        done,
    output logic [31:0] rdat,
    output logic        timeout,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam int LAT_LAST_I = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [1:0] LAT_LAST = LAT_LAST_I[1:0];
    localparam logic NO_LAT = (RD_LAT == 0);

    typedef enum logic [1:0] {X_IDLE, X_BUS, X_LAT} xfer_phase_t;

    xfer_phase_t     phase;
    logic [1:0]      lat_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            ack_hit;
    logic            lat_done;

    assign ack_hit  = (phase == X_BUS) && wb_ack_i;
    assign lat_done = (phase == X_LAT) && (lat_cnt == LAT_LAST);
    assign done     = (ack_hit && (wb_we_o || NO_LAT)) || lat_done;
    assign timeout  = (phase == X_BUS) && !wb_ack_i && (to_cnt == TO_LAST);
    assign rdat     = wb_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            phase    <= X_IDLE;
            lat_cnt  <= '0;
            to_cnt   <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            case (phase)
                X_BUS: begin
                    if (wb_ack_i || to_cnt == TO_LAST) begin
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= '0;
                        to_cnt   <= '0;
                        lat_cnt  <= '0;
                        phase    <= (wb_ack_i && !wb_we_o && !NO_LAT) ? X_LAT : X_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                X_LAT: begin
                    if (lat_cnt == LAT_LAST) phase <= X_IDLE;
                    else                     lat_cnt <= lat_cnt + 1'b1;
                end
                default: ;
            endcase
            // A new request may be chained onto the cycle that completes the previous one.
            if (start && (phase == X_IDLE || done)) begin
                phase    <= X_BUS;
                wb_stb_o <= 1'b1;
                wb_cyc_o <= 1'b1;
                wb_we_o  <= we;
                wb_adr_o <= adr;
                wb_dat_o <= we ? wdat : 32'd0;
                to_cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/corr_readout_master.sv
// Drains the correlator register bank over Wishbone and presents each I/Q set as a
// valid/ready frame. Define CORR_RD_SAT_EN to also read the SAT register (0x38).
module corr_readout_master
    import corr_readout_master_pkg::*;
#(
    parameter int POLL_DIV    = 64,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             enable,
    input  logic             err_clr,
    output logic [7:0]       wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic             wb_we_o,
    output logic             wb_stb_o,
    output logic             wb_cyc_o,
    input  logic             wb_ack_i,
    output logic             frm_valid,
    input  logic             frm_ready,
    output logic [FRM_W-1:0] frm_pi,
    output logic [FRM_W-1:0] frm_pq,
    output logic [FRM_W-1:0] frm_li,
    output logic [FRM_W-1:0] frm_lq,
    output logic [FRM_W-1:0] frm_ei,
    output logic [FRM_W-1:0] frm_eq,
    output logic             frm_acq,
`ifdef CORR_RD_SAT_EN
    output logic [4:0]       frm_sat_id,
    output logic [0:0]       frm_sat_chg,
`endif
    output logic             busy,
    output logic             timeout_err
);

`ifdef CORR_RD_SAT_EN
    localparam logic [2:0] SEQ_LAST = 3'd7;
`else
    localparam logic [2:0] SEQ_LAST = 3'd6;
`endif
    localparam int PC_W = $clog2(POLL_DIV);
    localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_DIV - 1);

    seq_state_t      state;
    logic [PC_W-1:0] poll_cnt;
    logic [2:0]      seq_idx;
    logic            xfer_start, xfer_we, xfer_done, xfer_timeout;
    logic [7:0]      xfer_adr;
    logic [31:0]     xfer_rdat;
    logic            in_read, poll_hit, rd_next, wr_next, bus_ack;
    logic            unused_rdat_hi;

    assign in_read  = (state == ST_RD_REQ) || (state == ST_RD_WAIT);
    assign poll_hit = (state == ST_IDLE) && enable && (poll_cnt == POLL_LAST);
    assign rd_next  = in_read && xfer_done &&
                      ((seq_idx == 3'd0) ? xfer_rdat[STATUS_RDY_BIT] : (seq_idx != SEQ_LAST));
    assign wr_next  = in_read && xfer_done && (seq_idx == SEQ_LAST);
    assign bus_ack  = wb_stb_o && wb_ack_i;

    // Requests are issued on the decision cycle so stb rises on the same edge as the state change.
    assign xfer_start = poll_hit || rd_next || wr_next;
    assign xfer_we    = wr_next;
    assign xfer_adr   = (poll_hit || wr_next) ? ADR_STATUS : seq_addr(seq_idx + 3'd1);

    assign busy           = (state != ST_IDLE);
    assign unused_rdat_hi = ^xfer_rdat[31:FRM_W];

    corr_readout_master_wb_single_xfer #(
        .RD_LAT      (RD_LAT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_xfer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start    (xfer_start),
        .we       (xfer_we),
        .adr      (xfer_adr),
        .wdat     (32'd0),
        .done     (xfer_done),
        .rdat     (xfer_rdat),
        .timeout  (xfer_timeout),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_ack_i (wb_ack_i)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            poll_cnt    <= '0;
            seq_idx     <= '0;
            frm_valid   <= 1'b0;
            timeout_err <= 1'b0;
            frm_acq     <= 1'b0;
            frm_pi      <= '0;
            frm_pq      <= '0;
            frm_li      <= '0;
            frm_lq      <= '0;
            frm_ei      <= '0;
            frm_eq      <= '0;
`ifdef CORR_RD_SAT_EN
            frm_sat_id  <= '0;
            frm_sat_chg <= '0;
`endif
        end else begin
            if (xfer_timeout)  timeout_err <= 1'b1;
            else if (err_clr)  timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!enable) begin
                        poll_cnt <= '0;
                    end else if (poll_hit) begin
                        poll_cnt <= '0;
                        seq_idx  <= '0;
                        state    <= ST_RD_REQ;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                ST_RD_REQ, ST_RD_WAIT: begin
                    if (xfer_timeout) begin
                        state <= ST_IDLE;
                    end else if (xfer_done) begin
                        case (seq_idx)
                            3'd0: if (xfer_rdat[STATUS_RDY_BIT]) frm_acq <= xfer_rdat[STATUS_ACQ_BIT];
                            3'd1: frm_pi <= xfer_rdat[FRM_W-1:0];
                            3'd2: frm_pq <= xfer_rdat[FRM_W-1:0];
                            3'd3: frm_li <= xfer_rdat[FRM_W-1:0];
                            3'd4: frm_lq <= xfer_rdat[FRM_W-1:0];
                            3'd5: frm_ei <= xfer_rdat[FRM_W-1:0];
                            3'd6: frm_eq <= xfer_rdat[FRM_W-1:0];
`ifdef CORR_RD_SAT_EN
                            3'd7: begin
                                frm_sat_id  <= xfer_rdat[SAT_ID_W-1:0];
                                frm_sat_chg <= xfer_rdat[SAT_CHG_BIT];
                            end
`endif
                            default: ;
                        endcase
                        seq_idx <= seq_idx + 3'd1;
                        state   <= rd_next ? ST_RD_REQ : (wr_next ? ST_WR_CLR : ST_IDLE);
                    end else if (bus_ack) begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_WR_CLR: begin
                    if (xfer_timeout) begin
                        state <= ST_IDLE;
                    end else if (xfer_done) begin
                        frm_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (frm_ready) begin
                        frm_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corr_readout_master.sv
// Directed bench for corr_readout_master with a registered-read Wishbone slave model.
module tb_corr_readout_master;

    logic        clk = 1'b0;
    logic        rst, enable, err_clr, frm_ready;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic        frm_valid, frm_acq, busy, timeout_err;
    logic [19:0] frm_pi, frm_pq, frm_li, frm_lq, frm_ei, frm_eq;
`ifdef CORR_RD_SAT_EN
    logic [4:0]  frm_sat_id;
    logic [0:0]  frm_sat_chg;
    localparam int SEQ_N = 8;
`else
    localparam int SEQ_N = 7;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] status_val = 32'd0;
    logic [31:0] sat_val    = 32'h25;
    logic        noack_en   = 1'b0;
    logic [7:0]  noack_adr  = 8'h1C;
    logic [40:0] log_q[$];
    int          log_base = 0;

    always #5 clk = ~clk;

    corr_readout_master dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .enable      (enable),
        .err_clr     (err_clr),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_ack_i    (wb_ack_i),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .frm_pi      (frm_pi),
        .frm_pq      (frm_pq),
        .frm_li      (frm_li),
        .frm_lq      (frm_lq),
        .frm_ei      (frm_ei),
        .frm_eq      (frm_eq),
        .frm_acq     (frm_acq),
`ifdef CORR_RD_SAT_EN
        .frm_sat_id  (frm_sat_id),
        .frm_sat_chg (frm_sat_chg),
`endif
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Data registers carry junk above bit 19 so truncation to 20 bits is exercised.
    function automatic logic [31:0] slave_rd(input logic [7:0] a);
        case (a)
            8'h30:   return status_val;
            8'h18:   return 32'hFFF0_0001;
            8'h1C:   return 32'hFFF0_0002;
            8'h20:   return 32'hFFF0_0003;
            8'h24:   return 32'hFFF0_0004;
            8'h28:   return 32'hFFF0_0005;
            8'h2C:   return 32'hFFF0_0006;
            8'h38:   return sat_val;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Registered slave: ack one cycle after stb, read data valid the cycle after ack.
    always @(posedge clk) begin
        if (rst) begin
            wb_ack_i <= 1'b0;
            wb_dat_i <= 32'd0;
        end else begin
            wb_ack_i <= wb_stb_o && !wb_ack_i && !(noack_en && wb_adr_o == noack_adr);
            if (wb_stb_o && wb_ack_i && !wb_we_o) wb_dat_i <= slave_rd(wb_adr_o);
        end
    end

    always @(posedge clk) begin
        if (wb_stb_o && wb_ack_i) log_q.push_back({wb_we_o, wb_adr_o, wb_dat_o});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; err_clr = 1'b0; frm_ready = 1'b0;
        step(3);
        checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", wb_stb_o); end
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b want 0", wb_cyc_o); end
        checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb_we_o); end
        checks++; if (wb_adr_o !== 8'h00) begin errors++; $display("FAIL reset_adr got %h want 00", wb_adr_o); end
        checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL reset_dat got %h want 0", wb_dat_o); end
        checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frm_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b want 0", timeout_err); end
        checks++; if (frm_pi !== 20'd0 || frm_acq !== 1'b0) begin errors++; $display("FAIL reset_frame got pi=%h acq=%b want 0/0", frm_pi, frm_acq); end
    endtask

    task automatic test_idle_poll;
        int n;
        status_val = 32'd0;
        log_base = log_q.size();
        rst = 1'b0; enable = 1'b1;
        step(63);
        checks++; if (wb_stb_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL poll_early got stb=%b busy=%b want 0/0", wb_stb_o, busy); end
        step(1);
        checks++; if (wb_stb_o !== 1'b1 || wb_adr_o !== 8'h30 || wb_we_o !== 1'b0) begin
            errors++; $display("FAIL poll_start got stb=%b adr=%h we=%b want 1/30/0", wb_stb_o, wb_adr_o, wb_we_o); end
        n = 0;
        while (busy && n < 20) begin step(1); n++; end
        checks++; if (n !== 3) begin errors++; $display("FAIL poll_busy_len got %0d want 3", n); end
        checks++; if (log_q.size() - log_base !== 1) begin errors++; $display("FAIL poll_count got %0d want 1", log_q.size() - log_base); end
        checks++; if (log_q[log_base] !== {1'b0, 8'h30, 32'd0}) begin errors++; $display("FAIL poll_xfer got %h want 03000000000", log_q[log_base]); end
        checks++; if (frm_valid !== 1'b0) begin errors++; $display("FAIL poll_noframe got %b want 0", frm_valid); end
        n = 0;
        while (!wb_stb_o && n < 100) begin
            step(1); n++;
            if (busy && !wb_stb_o) begin errors++; $display("FAIL poll_gap_busy got 1 want 0"); end
        end
        checks++; if (n !== 64) begin errors++; $display("FAIL poll_period got %0d want 64", n); end
        n = 0;
        while (busy && n < 20) begin step(1); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL poll2_done got busy=%b want 0", busy); end
    endtask

    task automatic test_frame;
        int n;
        logic [7:0] exp_adr [9];
        exp_adr = '{8'h30, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h38, 8'h30};
`ifndef CORR_RD_SAT_EN
        exp_adr[7] = 8'h30;
`endif
        status_val = 32'h3;
        log_base = log_q.size();
        n = 0;
        while (!frm_valid && n < 400) begin step(1); n++; end
        checks++; if (frm_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b want 1", frm_valid); end
        checks++; if (log_q.size() - log_base !== SEQ_N + 1) begin errors++; $display("FAIL frame_xfers got %0d want %0d", log_q.size() - log_base, SEQ_N + 1); end
        for (int i = 0; i <= SEQ_N && log_base + i < log_q.size(); i++) begin
            checks++;
            if (log_q[log_base + i] !== {(i == SEQ_N), exp_adr[i], 32'd0}) begin
                errors++; $display("FAIL frame_xfer%0d got %h want we=%0d adr=%h dat=0", i, log_q[log_base + i], (i == SEQ_N), exp_adr[i]);
            end
        end
        checks++; if ({frm_pi, frm_pq, frm_li} !== {20'd1, 20'd2, 20'd3}) begin errors++; $display("FAIL frame_p_l got %h %h %h want 1 2 3", frm_pi, frm_pq, frm_li); end
        checks++; if ({frm_lq, frm_ei, frm_eq} !== {20'd4, 20'd5, 20'd6}) begin errors++; $display("FAIL frame_l_e got %h %h %h want 4 5 6", frm_lq, frm_ei, frm_eq); end
        checks++; if (frm_acq !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL frame_acq_busy got %b/%b want 1/1", frm_acq, busy); end
`ifdef CORR_RD_SAT_EN
        checks++; if (frm_sat_id !== 5'd5 || frm_sat_chg !== 1'b1) begin errors++; $display("FAIL frame_sat got id=%0d chg=%b want 5/1", frm_sat_id, frm_sat_chg); end
`endif
    endtask

    task automatic test_backpressure;
        int n;
        logic stb_seen;
        status_val = 32'd0;
        log_base = log_q.size();
        stb_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (wb_stb_o) stb_seen = 1'b1;
        end
        checks++; if (frm_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", frm_valid); end
        checks++; if (frm_pi !== 20'd1 || frm_eq !== 20'd6) begin errors++; $display("FAIL bp_stable got pi=%h eq=%h want 1/6", frm_pi, frm_eq); end
        checks++; if (stb_seen !== 1'b0 || log_q.size() !== log_base) begin errors++; $display("FAIL bp_nobus got stb_seen=%b xfers=%0d want 0/0", stb_seen, log_q.size() - log_base); end
        frm_ready = 1'b1;
        step(1);
        frm_ready = 1'b0;
        checks++; if (frm_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drop got valid=%b busy=%b want 0/0", frm_valid, busy); end
        n = 0;
        while (!wb_stb_o && n < 100) begin step(1); n++; end
        checks++; if (n !== 64 || wb_adr_o !== 8'h30) begin errors++; $display("FAIL bp_resume got %0d cycles adr=%h want 64/30", n, wb_adr_o); end
        n = 0;
        while (busy && n < 20) begin step(1); n++; end
    endtask

    task automatic test_timeout;
        int n;
        status_val = 32'h3;
        noack_en = 1'b1;
        log_base = log_q.size();
        n = 0;
        while (!(wb_stb_o && wb_adr_o == 8'h1C) && n < 200) begin step(1); n++; end
        checks++; if (!(wb_stb_o && wb_adr_o == 8'h1C)) begin errors++; $display("FAIL to_reach got adr=%h stb=%b want 1C/1", wb_adr_o, wb_stb_o); end
        n = 0;
        while (wb_stb_o && n < 40) begin step(1); n++; end
        status_val = 32'd0;
        noack_en = 1'b0;
        checks++; if (n !== 16) begin errors++; $display("FAIL to_len got %0d want 16", n); end
        checks++; if (timeout_err !== 1'b1 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL to_flag got terr=%b cyc=%b want 1/0", timeout_err, wb_cyc_o); end
        checks++; if (busy !== 1'b0 || frm_valid !== 1'b0) begin errors++; $display("FAIL to_abort got busy=%b valid=%b want 0/0", busy, frm_valid); end
        checks++; if (log_q.size() - log_base !== 2) begin errors++; $display("FAIL to_xfers got %0d want 2", log_q.size() - log_base); end
        step(5);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout_err); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", timeout_err); end
    endtask

    task automatic test_reset_mid;
        int n;
        status_val = 32'h3;
        n = 0;
        while (!(wb_stb_o && wb_adr_o == 8'h20) && n < 200) begin step(1); n++; end
        n = 0;
        while (wb_stb_o && n < 20) begin step(1); n++; end
        checks++; if (busy !== 1'b1 || wb_stb_o !== 1'b0 || wb_adr_o !== 8'h20) begin
            errors++; $display("FAIL rm_wait got busy=%b stb=%b adr=%h want 1/0/20", busy, wb_stb_o, wb_adr_o); end
        rst = 1'b1;
        step(1);
        checks++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || wb_adr_o !== 8'h00 || wb_dat_o !== 32'd0) begin
            errors++; $display("FAIL rm_bus got stb=%b cyc=%b adr=%h dat=%h want 0", wb_stb_o, wb_cyc_o, wb_adr_o, wb_dat_o); end
        checks++; if (busy !== 1'b0 || frm_valid !== 1'b0 || frm_pi !== 20'd0 || frm_acq !== 1'b0) begin
            errors++; $display("FAIL rm_outs got busy=%b valid=%b pi=%h acq=%b want 0", busy, frm_valid, frm_pi, frm_acq); end
        rst = 1'b0;
        n = 0;
        while (!wb_stb_o && n < 100) begin step(1); n++; end
        checks++; if (n !== 64 || wb_adr_o !== 8'h30) begin errors++; $display("FAIL rm_restart got %0d cycles adr=%h want 64/30", n, wb_adr_o); end
        n = 0;
        while (!frm_valid && n < 200) begin step(1); n++; end
        checks++; if (frm_valid !== 1'b1 || frm_pi !== 20'd1 || frm_eq !== 20'd6) begin
            errors++; $display("FAIL rm_frame got valid=%b pi=%h eq=%h want 1/1/6", frm_valid, frm_pi, frm_eq); end
        status_val = 32'd0;
        frm_ready = 1'b1;
        step(1);
        frm_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_poll();
        test_frame();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
